// File: rtl/display_serial.sv
// display_serial: shows a captured word one bit at a time as 7-segment "0"/"1" patterns with blank gaps
module display_serial #(
  parameter int WIDTH = 4,
  parameter int DWELL = 4,
  parameter int MSB_FIRST = 1,
  localparam int IDXW = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic [WIDTH-1:0] entrada,
  output logic [6:0]       display,
  output logic             busy,
  output logic             done,
  output logic [IDXW-1:0]  bit_idx
);
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [IDXW-1:0] FIRST = MSB_FIRST != 0 ? IDXW'(WIDTH - 1) : '0;
  localparam logic [IDXW-1:0] LAST = MSB_FIRST != 0 ? '0 : IDXW'(WIDTH - 1);
  localparam logic [CW-1:0] CMAX = CW'(DWELL - 1);
  typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] word;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] nxt;
  logic [CW-1:0] cnt;
  function automatic logic [6:0] pat(input logic b);
    return b ? 7'b0000110 : 7'b0111111;
  endfunction
  always_comb nxt = MSB_FIRST != 0 ? idx - 1'b1 : idx + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      display <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      bit_idx <= '0;
      idx <= '0;
      cnt <= '0;
      word <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy <= ready;
          done <= 1'b0;
          if (ready) begin
            word <= entrada;
            idx <= FIRST;
            bit_idx <= FIRST;
            cnt <= '0;
            display <= pat(entrada[FIRST]);
            state <= SHOW;
          end
        end
        SHOW: begin
          if (cnt == CMAX) begin
            cnt <= '0;
            display <= '0;
            bit_idx <= '0;
            done <= idx == LAST;
            state <= idx == LAST ? DONE : GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          idx <= nxt;
          bit_idx <= nxt;
          display <= pat(word[nxt]);
          state <= SHOW;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_display_serial.sv
// tb_display_serial: directed checks of display_serial in MSB-first, LSB-first and single-bit configurations
module tb_display_serial;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ready0 = 1'b0, ready1 = 1'b0, ready2 = 1'b0;
  logic [3:0] entrada0 = '0, entrada1 = '0;
  logic [0:0] entrada2 = '0;
  logic [6:0] display0, display1, display2;
  logic busy0, busy1, busy2, done0, done1, done2;
  logic [1:0] bit_idx0, bit_idx1;
  logic [0:0] bit_idx2;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  display_serial #(.WIDTH(4), .DWELL(3), .MSB_FIRST(1)) d0 (
    .clk(clk), .reset(reset), .ready(ready0), .entrada(entrada0),
    .display(display0), .busy(busy0), .done(done0), .bit_idx(bit_idx0)
  );
  display_serial #(.WIDTH(4), .DWELL(3), .MSB_FIRST(0)) d1 (
    .clk(clk), .reset(reset), .ready(ready1), .entrada(entrada1),
    .display(display1), .busy(busy1), .done(done1), .bit_idx(bit_idx1)
  );
  display_serial #(.WIDTH(1), .DWELL(1), .MSB_FIRST(1)) d2 (
    .clk(clk), .reset(reset), .ready(ready2), .entrada(entrada2),
    .display(display2), .busy(busy2), .done(done2), .bit_idx(bit_idx2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] pat(input byte c);
    return c == "1" ? 7'b0000110 : c == "0" ? 7'b0111111 : 7'b0000000;
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic sample(input int w, output logic [6:0] d, output logic b, output logic dn, output int ix);
    case (w)
      0: begin d = display0; b = busy0; dn = done0; ix = int'(bit_idx0); end
      1: begin d = display1; b = busy1; dn = done1; ix = int'(bit_idx1); end
      default: begin d = display2; b = busy2; dn = done2; ix = int'(bit_idx2); end
    endcase
  endtask
  task automatic run(input int w, input string ds, input string is, input int n, input bit tog);
    logic [6:0] d;
    logic b, dn;
    int ix;
    for (int i = 1; i <= ds.len(); i++) begin
      sample(w, d, b, dn, ix);
      chk($sformatf("w%0d c%0d display", w, i), 32'(d), 32'(pat(ds[i-1])));
      chk($sformatf("w%0d c%0d bit_idx", w, i), 32'(ix), 32'(is[i-1] - "0"));
      chk($sformatf("w%0d c%0d busy", w, i), 32'(b), 32'(i < n));
      chk($sformatf("w%0d c%0d done", w, i), 32'(dn), 32'(i == n - 1));
      if (tog) entrada0 = i % 2 == 0 ? 4'b1100 : 4'b0011;
      if (i < ds.len()) step();
    end
  endtask
  initial begin
    logic [6:0] d;
    logic b, dn;
    int ix;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int w = 0; w < 3; w++) begin
      sample(w, d, b, dn, ix);
      chk($sformatf("w%0d reset display", w), 32'(d), 32'd0);
      chk($sformatf("w%0d reset busy", w), 32'(b), 32'd0);
      chk($sformatf("w%0d reset done", w), 32'(dn), 32'd0);
      chk($sformatf("w%0d reset bit_idx", w), 32'(ix), 32'd0);
    end
    step();
    ready0 = 1'b1;
    entrada0 = 4'b1010;
    step();
    ready0 = 1'b0;
    entrada0 = 4'b0101;
    run(0, "111-000-111-000--", "33302220111000000", 17, 1'b0);
    ready1 = 1'b1;
    entrada1 = 4'b1010;
    step();
    ready1 = 1'b0;
    entrada1 = 4'b1111;
    run(1, "000-111-000-111--", "00001110222033300", 17, 1'b0);
    ready2 = 1'b1;
    entrada2 = 1'b1;
    step();
    ready2 = 1'b0;
    entrada2 = 1'b0;
    run(2, "1--", "000", 3, 1'b0);
    ready0 = 1'b1;
    entrada0 = 4'b1010;
    step();
    ready0 = 1'b0;
    run(0, "111-00", "333022", 17, 1'b0);
    reset = 1'b1;
    ready0 = 1'b1;
    step();
    reset = 1'b0;
    ready0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort c%0d display", i), 32'(display0), 32'd0);
      chk($sformatf("abort c%0d busy", i), 32'(busy0), 32'd0);
      chk($sformatf("abort c%0d done", i), 32'(done0), 32'd0);
      chk($sformatf("abort c%0d bit_idx", i), 32'(bit_idx0), 32'd0);
      step();
    end
    ready0 = 1'b1;
    entrada0 = 4'b0110;
    step();
    ready0 = 1'b0;
    run(0, "000-111-111-000--", "33302220111000000", 17, 1'b0);
    ready0 = 1'b1;
    entrada0 = 4'b1100;
    step();
    run(0, "111-111-000-000--", "33302220111000000", 17, 1'b1);
    step();
    chk("hold second word display", 32'(display0), 32'(pat("0")));
    chk("hold second word busy", 32'(busy0), 32'd1);
    chk("hold second word bit_idx", 32'(bit_idx0), 32'd3);
    ready0 = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("hold second word bit 2", 32'(display0), 32'(pat("0")));
    for (int i = 0; i < 40 && busy0; i++) step();
    chk("drain busy", 32'(busy0), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/display_serial.md
DISPLAY_SERIAL -- requirements
Module: display_serial

Interface
REQ-001 Parameter WIDTH, default 4, number of bits in the word to display serially (WIDTH >= 1).
REQ-002 Parameter DWELL, default 4, clock cycles each bit is shown (DWELL >= 1).
REQ-003 Parameter MSB_FIRST, default 1, 1 = bit WIDTH-1 shown first, 0 = bit 0 shown first.
REQ-004 Derived constant IDXW = max(1, clog2(WIDTH)).
REQ-005 clk  input  1  system clock, all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 ready  input  1  start request, sampled only in IDLE.
REQ-008 entrada  input  WIDTH  encoded word to display, captured on accepted ready.
REQ-009 display  output  7  registered 7-segment pattern, bit0 = segment A … bit6 = segment G, 1 = segment lit.
REQ-010 busy  output  1  high while a word is in progress (SHOW, GAP, DONE).
REQ-011 done  output  1  one-cycle pulse marking end of a word.
REQ-012 bit_idx  output  IDXW  index into entrada of the bit currently shown; 0 outside SHOW.

Function
REQ-013 States: IDLE, SHOW, GAP, DONE; all outputs registered.
REQ-014 Patterns: bit 0 -> 7'b0111111, bit 1 -> 7'b0000110, blank -> 7'b0000000.
REQ-015 IDLE: display blank, busy 0, done 0; on ready=1 at edge k, capture entrada into an internal register, go to SHOW with first bit index (WIDTH-1 if MSB_FIRST else 0), dwell counter 0.
REQ-016 Latency: first bit pattern on display in cycle k+1 (the cycle after the accepting edge); busy=1 from cycle k+1.
REQ-017 SHOW: display = pattern of captured[bit_idx] for exactly DWELL cycles; dwell counter counts 0..DWELL-1.
REQ-018 On SHOW dwell expiry: if the shown bit is the last (index 0 if MSB_FIRST, else WIDTH-1), go to DONE, else go to GAP.
REQ-019 GAP: exactly 1 cycle, display blank, bit_idx steps by one (down if MSB_FIRST, up otherwise), then SHOW with counter 0.
REQ-020 DONE: exactly 1 cycle, display blank, done=1, busy=1; next state IDLE.
REQ-021 Total busy cycles per word = WIDTH*DWELL + (WIDTH-1) + 1; WIDTH=1 has no GAP.
REQ-022 ready and entrada are ignored in SHOW, GAP, DONE; entrada changes after capture have no effect.
REQ-023 ready held high continuously: new word accepted on the first IDLE edge after DONE, i.e. one IDLE cycle between words.
REQ-024 DWELL=1 shall display each bit for exactly one cycle, with gaps unchanged.

Reset
REQ-025 reset=1 at a rising edge forces state IDLE, display 7'b0000000, busy 0, done 0, bit_idx 0, counter and capture register 0, from the next cycle.
REQ-026 reset has priority over ready and over any in-progress word; a reset mid-word aborts it with no done pulse.
REQ-027 A ready asserted in the same cycle as reset is dropped.

Verification
REQ-028 WIDTH=4, DWELL=3, MSB_FIRST=1, entrada=4'b1010, ready pulse at edge k -> cycles k+1..k+3 0000110, k+4 blank, k+5..k+7 0111111, k+8 blank, k+9..k+11 0000110, k+12 blank, k+13..k+15 0111111, k+16 done=1 blank, k+17 busy=0.
REQ-029 Same word with MSB_FIRST=0 -> order 0,1,0,1 (0111111 first), bit_idx 0,1,2,3, done at k+16.
REQ-030 reset asserted at k+6 of REQ-028 run -> from k+7 display blank, busy 0, bit_idx 0, done never pulses; later ready starts a fresh word with correct timing.
REQ-031 ready held high with entrada toggling every cycle -> only values present at accepting edges are displayed, words separated by exactly one IDLE cycle.
REQ-032 WIDTH=1, DWELL=1, entrada=1 -> k+1 0000110, k+2 done=1 blank, k+3 busy=0.
